gzip_job_sequencer: RTL and testbench



---
 rtl/gzip_pkg.sv | 19 +
 rtl/gzip_seq_watchdog.sv | 30 +++
 rtl/gzip_job_sequencer.sv | 147 ++++++++++++++
 tb/tb_gzip_job_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gzip_pkg.sv
// rtl/gzip_pkg.sv - shared types and constants for the gzip job sequencer
package gzip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    localparam logic [1:0] BTYPE_STORED = 2'b00;
    localparam logic [1:0] BTYPE_FIXED  = 2'b01;

    localparam int ERR_BSIZE   = 0;
    localparam int ERR_BTYPE   = 1;
    localparam int ERR_TIMEOUT = 2;

endpackage

// File: rtl/gzip_seq_watchdog.sv
// rtl/gzip_seq_watchdog.sv - loadable saturating drain watchdog counter
module gzip_seq_watchdog #(
    parameter int WIDTH = 20
) (
    input  logic             core_clock,
    input  logic             bus_reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    assign expired = (count == '1);

    always_ff @(posedge core_clock or posedge bus_reset) begin
        if (bus_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gzip_job_sequencer.sv
// rtl/gzip_job_sequencer.sv - sequences one deflate job through gzip_top
// Optional drain watchdog: GZIP_SEQ_TIMEOUT_EN
module gzip_job_sequencer
    import gzip_pkg::*;
#(
    parameter int CNT_WIDTH  = 24,
    parameter int RST_CYCLES = 4,
    parameter int TMO_WIDTH  = 20
) (
    input  logic                 core_clock,
    input  logic                 bus_reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           cfg_btype,
    input  logic                 cfg_rev_endianness,
    input  logic [CNT_WIDTH-1:0] cfg_word_count,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 core_full,
    output logic                 core_wren,
    output logic                 gzip_rst_n,
    output logic [1:0]           btype,
    output logic                 rev_endianness,
    input  logic                 core_done,
    input  logic                 core_btype_err,
    input  logic                 core_bsize_err,
    input  logic [31:0]          core_isize,
    input  logic [31:0]          core_crc32,
    output logic                 busy,
    output logic                 irq,
    input  logic                 irq_clear,
    output logic [31:0]          res_isize,
    output logic [31:0]          res_crc32,
    output logic [2:0]           res_err,
    output logic [CNT_WIDTH-1:0] words_left
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    seq_state_t     state;
    logic [RCW-1:0] rst_cnt;
    logic           timeout_flag;
    logic           wd_expired;

    assign busy      = (state != ST_IDLE);
    assign in_ready  = (state == ST_STREAM) && !core_full;
    assign core_wren = in_valid && in_ready;

`ifdef GZIP_SEQ_TIMEOUT_EN
    logic drain_entry;

    // Loading 1 on entry makes the all-ones compare fire on the (2^W-1)th DRAIN cycle
    assign drain_entry = ((state == ST_RESET) && (rst_cnt == '0) && (words_left == '0)) ||
                         (core_wren && (words_left == CNT_WIDTH'(1)));

    gzip_seq_watchdog #(.WIDTH(TMO_WIDTH)) u_watchdog (
        .core_clock (core_clock),
        .bus_reset  (bus_reset),
        .clear      (abort || (state == ST_IDLE)),
        .load       (drain_entry),
        .load_value (TMO_WIDTH'(1)),
        .enable     (state == ST_DRAIN),
        .expired    (wd_expired)
    );
`else
    logic [TMO_WIDTH-1:0] unused_tmo;
    assign unused_tmo = '0;
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge core_clock or posedge bus_reset) begin
        if (bus_reset) begin
            state          <= ST_IDLE;
            rst_cnt        <= '0;
            gzip_rst_n     <= 1'b0;
            btype          <= '0;
            rev_endianness <= 1'b0;
            words_left     <= '0;
            timeout_flag   <= 1'b0;
            res_isize      <= '0;
            res_crc32      <= '0;
            res_err        <= '0;
        end else if (abort && (state != ST_IDLE)) begin
            state      <= ST_IDLE;
            gzip_rst_n <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        btype          <= cfg_btype;
                        rev_endianness <= cfg_rev_endianness;
                        words_left     <= cfg_word_count;
                        rst_cnt        <= RCW'(RST_CYCLES - 1);
                        gzip_rst_n     <= 1'b0;
                        timeout_flag   <= 1'b0;
                        state          <= ST_RESET;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt == '0) begin
                        gzip_rst_n <= 1'b1;
                        state      <= (words_left == '0) ? ST_DRAIN : ST_STREAM;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (core_wren) begin
                        words_left <= words_left - 1'b1;
                        if (words_left == CNT_WIDTH'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (core_done) begin
                        state <= ST_DONE;
                    end else if (wd_expired) begin
                        timeout_flag <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    res_isize            <= core_isize;
                    res_crc32            <= core_crc32;
                    res_err[ERR_TIMEOUT] <= timeout_flag;
                    res_err[ERR_BTYPE]   <= core_btype_err;
                    res_err[ERR_BSIZE]   <= core_bsize_err;
                    state                <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Completion beats a same-cycle clear so an interrupt is never lost
    always_ff @(posedge core_clock or posedge bus_reset) begin
        if (bus_reset) begin
            irq <= 1'b0;
        end else if ((state == ST_DONE) && !abort) begin
            irq <= 1'b1;
        end else if (irq_clear) begin
            irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gzip_job_sequencer.sv
// tb/tb_gzip_job_sequencer.sv - scoreboard bench for gzip_job_sequencer
`timescale 1ns/1ps
module tb_gzip_job_sequencer;

    localparam int CNT_WIDTH  = 24;
    localparam int RST_CYCLES = 4;
`ifdef GZIP_SEQ_TIMEOUT_EN
    localparam int TMO_WIDTH  = 4;
`else
    localparam int TMO_WIDTH  = 20;
`endif

    localparam int K_DONE  = 0;
    localparam int K_ABORT = 1;
    localparam int K_RESET = 2;
    localparam int K_TMO   = 3;

    logic                 core_clock = 1'b0;
    logic                 bus_reset  = 1'b1;
    logic                 start = 1'b0, abort = 1'b0;
    logic [1:0]           cfg_btype = '0;
    logic                 cfg_rev_endianness = 1'b0;
    logic [CNT_WIDTH-1:0] cfg_word_count = '0;
    logic                 in_valid = 1'b0, in_ready, core_full = 1'b0, core_wren;
    logic                 gzip_rst_n, rev_endianness;
    logic [1:0]           btype;
    logic                 core_done = 1'b0, core_btype_err = 1'b0, core_bsize_err = 1'b0;
    logic [31:0]          core_isize = '0, core_crc32 = '0;
    logic                 busy, irq, irq_clear = 1'b0;
    logic [31:0]          res_isize, res_crc32;
    logic [2:0]           res_err;
    logic [CNT_WIDTH-1:0] words_left;

    gzip_job_sequencer #(
        .CNT_WIDTH(CNT_WIDTH), .RST_CYCLES(RST_CYCLES), .TMO_WIDTH(TMO_WIDTH)
    ) dut (
        .core_clock(core_clock), .bus_reset(bus_reset), .start(start), .abort(abort),
        .cfg_btype(cfg_btype), .cfg_rev_endianness(cfg_rev_endianness),
        .cfg_word_count(cfg_word_count), .in_valid(in_valid), .in_ready(in_ready),
        .core_full(core_full), .core_wren(core_wren), .gzip_rst_n(gzip_rst_n),
        .btype(btype), .rev_endianness(rev_endianness), .core_done(core_done),
        .core_btype_err(core_btype_err), .core_bsize_err(core_bsize_err),
        .core_isize(core_isize), .core_crc32(core_crc32), .busy(busy), .irq(irq),
        .irq_clear(irq_clear), .res_isize(res_isize), .res_crc32(res_crc32),
        .res_err(res_err), .words_left(words_left)
    );

    always #5 core_clock = ~core_clock;

    typedef struct {
        int          total;
        int          words;
        logic [31:0] isize;
        logic [31:0] crc;
        logic [2:0]  err;
        logic        irq;
        logic        rst_n;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_isize = '0, m_crc = '0;
    logic [2:0]  m_err = '0;
    logic        m_irq = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge core_clock);
        #1;
    endtask

    // Monitor: counts admitted words per job and scores each job when busy falls
    initial begin
        int   wr_cnt;
        logic prev_busy;
        exp_t e;
        wr_cnt    = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge core_clock);
            if (core_full) check("in_ready_when_full", in_ready, 0);
            check("wren_is_valid_and_ready", core_wren, in_valid & in_ready);
            if (busy && !prev_busy) wr_cnt = 0;
            if (busy) begin
                if (exp_q.size() == 0) check("busy_without_job", busy, 0);
                else check("words_left", words_left, exp_q[0].total - wr_cnt);
            end
            if (core_wren) wr_cnt++;
            if (!busy && prev_busy) begin
                if (exp_q.size() == 0) begin
                    check("job_end_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("words_admitted", wr_cnt, e.words);
                    check("res_isize", res_isize, e.isize);
                    check("res_crc32", res_crc32, e.crc);
                    check("res_err", res_err, e.err);
                    check("irq_at_end", irq, e.irq);
                    check("gzip_rst_n_at_end", gzip_rst_n, e.rst_n);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic run_job(input int n, input int full_mode, input int kind, input int stop_at,
                           input logic [1:0] bt, input bit clr_in_done, input bit start_mid);
        exp_t        e;
        logic        rv;
        int          cnt, lows, guard, target, cyc;
        logic [31:0] d_isize, d_crc;
        rv = 1'($urandom);
        d_isize = $urandom;
        d_crc   = $urandom;
        e.total = n;
        e.words = (kind == K_ABORT || kind == K_RESET) ? stop_at : n;
        e.isize = d_isize;
        e.crc   = d_crc;
        e.err   = (kind == K_TMO) ? 3'b100 : {1'b0, 2'($urandom)};
        e.irq   = 1'b1;
        e.rst_n = 1'b1;
        if (kind == K_ABORT) begin
            e.isize = m_isize; e.crc = m_crc; e.err = m_err; e.irq = m_irq; e.rst_n = 1'b0;
        end else if (kind == K_RESET) begin
            e.isize = '0; e.crc = '0; e.err = '0; e.irq = 1'b0; e.rst_n = 1'b0;
        end
        exp_q.push_back(e);
        m_isize = e.isize; m_crc = e.crc; m_err = e.err; m_irq = e.irq;

        core_isize = d_isize;
        core_crc32 = d_crc;
        start = 1'b1; cfg_btype = bt; cfg_rev_endianness = rv; cfg_word_count = CNT_WIDTH'(n);
        tick();
        start = 1'b0; cfg_btype = ~bt; cfg_rev_endianness = ~rv; cfg_word_count = CNT_WIDTH'(77);
        check("busy_after_start", busy, 1);
        check("btype_latched", btype, bt);
        check("rev_latched", rev_endianness, rv);

        lows = 0;
        guard = 0;
        while (!gzip_rst_n && guard < 40) begin
            lows++;
            guard++;
            tick();
        end
        check("rst_low_cycles", lows, RST_CYCLES);

        target = e.words;
        cnt = 0;
        guard = 0;
        while (cnt < target && guard < 500) begin
            in_valid  = (full_mode == 2) ? 1'($urandom) : 1'b1;
            core_full = (full_mode == 1) ? guard[0] :
                        (full_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (start_mid && cnt == 1) begin
                start = 1'b1; cfg_word_count = CNT_WIDTH'(99);
            end
            @(negedge core_clock);
            if (core_wren) cnt++;
            tick();
            start = 1'b0;
            guard++;
        end
        check("stream_within_budget", guard < 500, 1);
        core_full = 1'b0;
        in_valid  = 1'b1;
        if (start_mid) check("btype_kept_after_ignored_start", btype, bt);

        if (kind == K_ABORT) begin
            in_valid = 1'b0;
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_idle", busy, 0);
            check("abort_rst_n", gzip_rst_n, 0);
            check("abort_irq_kept", irq, e.irq);
        end else if (kind == K_RESET) begin
            in_valid = 1'b0;
            bus_reset = 1'b1;
            #1;
            check("rst_busy", busy, 0);
            check("rst_rst_n", gzip_rst_n, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_btype", {rev_endianness, btype}, 0);
            check("rst_words_left", words_left, 0);
            check("rst_results", {res_isize, res_crc32} | 64'(res_err), 0);
            check("rst_irq", irq, 0);
            tick();
            bus_reset = 1'b0;
        end else if (kind == K_TMO) begin
            in_valid = 1'b0;
            cyc = 0;
            while (busy && cyc < 100) begin
                cyc++;
                tick();
            end
            check("timeout_busy_cycles", cyc, (1 << TMO_WIDTH));
        end else begin
            repeat ($urandom_range(0, 4)) tick();
            core_done = 1'b1;
            core_btype_err = e.err[1];
            core_bsize_err = e.err[0];
            tick();
            core_done = 1'b0;
            irq_clear = clr_in_done;
            check("done_cycle_busy", busy, 1);
            tick();
            irq_clear = 1'b0;
            check("done_busy_low", busy, 0);
            check("done_irq", irq, 1);
            core_btype_err = 1'b0;
            core_bsize_err = 1'b0;
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic clear_irq();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        m_irq = 1'b0;
        check("irq_cleared", irq, 0);
    endtask

    initial begin
        int n, kind, guard;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_rst_n", gzip_rst_n, 0);
        bus_reset = 1'b0;
        tick();
        check("reset_idle_outputs", {busy, gzip_rst_n, irq, in_ready, core_wren, rev_endianness, btype}, 0);
        check("reset_words_left", words_left, 0);
        check("reset_results", {res_isize, res_crc32} | 64'(res_err), 0);

        run_job(8, 0, K_DONE, 0, 2'b01, 1'b0, 1'b0);
        run_job(0, 0, K_DONE, 0, 2'b00, 1'b0, 1'b0);
        run_job(5, 1, K_DONE, 0, 2'b10, 1'b0, 1'b0);
        run_job(10, 0, K_ABORT, 3, 2'b01, 1'b0, 1'b0);
        clear_irq();
        run_job(6, 0, K_DONE, 0, 2'b01, 1'b1, 1'b0);
        run_job(7, 2, K_DONE, 0, 2'b11, 1'b0, 1'b1);
        run_job(10, 2, K_RESET, 4, 2'b01, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            n = $urandom_range(0, 12);
            kind = ($urandom_range(0, 3) == 0) ? K_ABORT : K_DONE;
            run_job(n, $urandom_range(0, 2), kind, $urandom_range(0, n), 2'($urandom),
                    1'($urandom), 1'b0);
            if ($urandom_range(0, 2) == 0) clear_irq();
        end
`ifdef GZIP_SEQ_TIMEOUT_EN
        run_job(2, 0, K_TMO, 0, 2'b01, 1'b0, 1'b0);
`endif
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            guard++;
            tick();
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
